// File: rtl/matrix_result_buffer_pkg.sv
// Shared definitions for the matrix result buffer: default dimension,
// FSM state encoding and the index range helper used by top and storage.
package matrix_result_buffer_pkg;

   localparam int M_DEFAULT     = 2;
   localparam int M_LEN_DEFAULT = $clog2(M_DEFAULT);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_ACK     = 3'd2,
      ST_RELEASE = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   function automatic logic idx_in_range(input int i, input int j, input int dim);
      return (i < dim) && (j < dim);
   endfunction

endpackage

// File: rtl/matrix_result_buffer_result_ram.sv
// m*m x 32 register array: one write port, two combinational read ports,
// single-cycle parallel clear. Out-of-range reads return zero.
module result_ram
   import matrix_result_buffer_pkg::*;
#(
   parameter int m     = M_DEFAULT,
   parameter int m_len = $clog2(m)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             we,
   input  logic [m_len-1:0] wr_i,
   input  logic [m_len-1:0] wr_j,
   input  logic [31:0]      wr_data,
   input  logic [m_len-1:0] rda_i,
   input  logic [m_len-1:0] rda_j,
   output logic [31:0]      rda_data,
   input  logic [m_len-1:0] rdb_i,
   input  logic [m_len-1:0] rdb_j,
   output logic [31:0]      rdb_data
);

   localparam int AW = $clog2(m * m);

   logic [31:0] mem_r [m * m];

   function automatic logic [AW-1:0] flat(input logic [m_len-1:0] i, input logic [m_len-1:0] j);
      return AW'(int'(i) * m + int'(j));
   endfunction

   // Storage array: async reset, synchronous clear, gated in-range write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < m * m; k++) mem_r[k] <= 32'h0;
      end else if (clr) begin
         for (int k = 0; k < m * m; k++) mem_r[k] <= 32'h0;
      end else if (we && idx_in_range(int'(wr_i), int'(wr_j), m)) begin
         mem_r[flat(wr_i, wr_j)] <= wr_data;
      end
   end

   // Read port A: lookup for the producer's current index
   always_comb begin
      rda_data = 32'h0;
      if (idx_in_range(int'(rda_i), int'(rda_j), m)) begin
         rda_data = mem_r[flat(rda_i, rda_j)];
      end else begin
         rda_data = 32'h0;
      end
   end

   // Read port B: lookup for the drain sequencer
   always_comb begin
      rdb_data = 32'h0;
      if (idx_in_range(int'(rdb_i), int'(rdb_j), m)) begin
         rdb_data = mem_r[flat(rdb_i, rdb_j)];
      end else begin
         rdb_data = 32'h0;
      end
   end

endmodule

// File: rtl/matrix_result_buffer.sv
// Collects m*m float32 results from a strobe/ack producer into result_ram,
// then drains them row-major over a valid/ready stream.
module matrix_result_buffer
   import matrix_result_buffer_pkg::*;
#(
   parameter int m     = M_DEFAULT,
   parameter int m_len = $clog2(m)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      z_in,
   input  logic [m_len-1:0] z_i,
   input  logic [m_len-1:0] z_j,
   input  logic             z_stb,
   output logic             z_ack,
   output logic [31:0]      current_element,
   input  logic             done_in,
   output logic [31:0]      out_data,
   output logic [m_len-1:0] out_i,
   output logic [m_len-1:0] out_j,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy,
   output logic             idx_err
);

   state_t           state_r, next_s;
   logic             z_ack_r, out_valid_r, out_last_r, busy_r, idx_err_r, done_seen_r;
   logic [31:0]      out_data_r;
   logic [m_len-1:0] out_i_r, out_j_r;

   logic             clr_s, wr_en_s, load_s, set_err_s, finish_s, at_last_s, accept_s;
   logic [m_len-1:0] nxt_i_s, nxt_j_s;
   logic [31:0]      rdb_data_s;

   result_ram #(.m(m), .m_len(m_len)) u_ram (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_s),
      .we       (wr_en_s),
      .wr_i     (z_i),
      .wr_j     (z_j),
      .wr_data  (z_in),
      .rda_i    (z_i),
      .rda_j    (z_j),
      .rda_data (current_element),
      .rdb_i    (nxt_i_s),
      .rdb_j    (nxt_j_s),
      .rdb_data (rdb_data_s)
   );

   assign at_last_s = (int'(out_i_r) == m - 1) && (int'(out_j_r) == m - 1);
   assign accept_s  = out_valid_r && out_ready;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= ST_IDLE;
      else      state_r <= next_s;
   end

   // Next-state logic
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE:    if (start) next_s = ST_COLLECT; else next_s = ST_IDLE;
         ST_COLLECT: begin
            // a pending strobe always wins over a drain request
            if (z_stb)            next_s = ST_ACK;
            else if (done_seen_r) next_s = ST_DRAIN;
            else                  next_s = ST_COLLECT;
         end
         ST_ACK:     next_s = ST_RELEASE;
         ST_RELEASE: if (!z_stb) next_s = ST_COLLECT; else next_s = ST_RELEASE;
         ST_DRAIN:   if (accept_s && at_last_s) next_s = ST_IDLE; else next_s = ST_DRAIN;
         default:    next_s = ST_IDLE;
      endcase
   end

   // Output/control decode: storage strobes and next drain index
   always_comb begin
      clr_s     = 1'b0;
      wr_en_s   = 1'b0;
      set_err_s = 1'b0;
      load_s    = 1'b0;
      finish_s  = 1'b0;
      nxt_i_s   = out_i_r;
      nxt_j_s   = out_j_r;
      case (state_r)
         ST_IDLE:    clr_s = start;
         ST_COLLECT: begin
            wr_en_s   = z_stb;
            set_err_s = z_stb && !idx_in_range(int'(z_i), int'(z_j), m);
            if (!z_stb && done_seen_r) begin
               load_s  = 1'b1;
               nxt_i_s = '0;
               nxt_j_s = '0;
            end else begin
               load_s  = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (accept_s && at_last_s) begin
               finish_s = 1'b1;
            end else if (accept_s) begin
               load_s = 1'b1;
               if (int'(out_j_r) == m - 1) begin
                  nxt_j_s = '0;
                  nxt_i_s = out_i_r + m_len'(1);
               end else begin
                  nxt_j_s = out_j_r + m_len'(1);
               end
            end else begin
               load_s = 1'b0;
            end
         end
         default: clr_s = 1'b0;
      endcase
   end

   // Registered outputs, drain index and sticky flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         z_ack_r     <= 1'b0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
         idx_err_r   <= 1'b0;
         done_seen_r <= 1'b0;
         out_data_r  <= 32'h0;
         out_i_r     <= '0;
         out_j_r     <= '0;
      end else begin
         z_ack_r     <= (next_s == ST_ACK);
         out_valid_r <= (next_s == ST_DRAIN);
         busy_r      <= (next_s != ST_IDLE);
         if (clr_s)          idx_err_r <= 1'b0;
         else if (set_err_s) idx_err_r <= 1'b1;
         if (clr_s || finish_s) done_seen_r <= 1'b0;
         else if (done_in && (state_r == ST_COLLECT || state_r == ST_ACK || state_r == ST_RELEASE))
            done_seen_r <= 1'b1;
         if (load_s) begin
            out_data_r <= rdb_data_s;
            out_i_r    <= nxt_i_s;
            out_j_r    <= nxt_j_s;
            out_last_r <= (int'(nxt_i_s) == m - 1) && (int'(nxt_j_s) == m - 1);
         end else if (finish_s) begin
            out_last_r <= 1'b0;
         end
      end
   end

   assign z_ack     = z_ack_r;
   assign out_valid = out_valid_r;
   assign out_last  = out_last_r;
   assign out_data  = out_data_r;
   assign out_i     = out_i_r;
   assign out_j     = out_j_r;
   assign busy      = busy_r;
   assign idx_err   = idx_err_r;

endmodule

// File: tb/tb_matrix_result_buffer.sv
// Randomized scoreboard bench for matrix_result_buffer with m=3, so that
// index value 3 exercises the out-of-range path.
module tb_matrix_result_buffer;

   localparam int M  = 3;
   localparam int ML = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0, z_stb = 1'b0, done_in = 1'b0, out_ready = 1'b0;
   logic [31:0]   z_in = 32'h0;
   logic [ML-1:0] z_i = '0, z_j = '0;
   logic          z_ack, out_valid, out_last, busy, idx_err;
   logic [31:0]   current_element, out_data;
   logic [ML-1:0] out_i, out_j;

   matrix_result_buffer #(.m(M), .m_len(ML)) dut (
      .clk(clk), .rst(rst), .start(start), .z_in(z_in), .z_i(z_i), .z_j(z_j),
      .z_stb(z_stb), .z_ack(z_ack), .current_element(current_element),
      .done_in(done_in), .out_data(out_data), .out_i(out_i), .out_j(out_j),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .idx_err(idx_err)
   );

   always #5 clk = ~clk;

   typedef struct { int i; int j; logic [31:0] d; bit last; } exp_t;

   int          checks = 0;
   int          failures = 0;
   int          acc_cnt = 0;
   logic [31:0] model_mem [M][M];
   bit          model_err;
   exp_t        exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: pops the scoreboard on every accepted beat, checks stall stability
   exp_t        mon_e;
   bit          stalled = 1'b0;
   logic [31:0] held_d;
   logic [ML-1:0] held_i, held_j;
   always @(negedge clk) begin
      if (out_valid) begin
         if (stalled) begin
            check("hold_data", out_data, held_d);
            check("hold_idx", {out_i, out_j}, {held_i, held_j});
         end
         if (out_ready) begin
            stalled = 1'b0;
            acc_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat actual=%h expected=none", out_data);
            end else begin
               mon_e = exp_q.pop_front();
               check("drain_data", out_data, mon_e.d);
               check("drain_i", 32'(out_i), 32'(mon_e.i));
               check("drain_j", 32'(out_j), 32'(mon_e.j));
               check("drain_last", 32'(out_last), 32'(mon_e.last));
            end
         end else begin
            stalled = 1'b1;
            held_d  = out_data;
            held_i  = out_i;
            held_j  = out_j;
         end
      end else begin
         stalled = 1'b0;
      end
   end

   task automatic model_clear();
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++) model_mem[i][j] = 32'h0;
      model_err = 1'b0;
   endtask

   task automatic do_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      model_clear();
      check("start_idx_err", 32'(idx_err), 32'h0);
      check("start_busy", 32'(busy), 32'h1);
   endtask

   task automatic do_write(input int i, input int j, input logic [31:0] d, input int hold, input bit with_done);
      int n;
      bit got;
      z_i = ML'(i); z_j = ML'(j); z_in = d; z_stb = 1'b1;
      if (with_done) done_in = 1'b1;
      n = 0; got = 1'b0;
      while (n < 6 && !got) begin
         @(negedge clk);
         n++;
         if (z_ack) got = 1'b1;
      end
      done_in = 1'b0;
      check("ack_latency", 32'(n), 32'd2);
      if (i < M && j < M) model_mem[i][j] = d;
      else model_err = 1'b1;
      check("cur_elem", current_element, (i < M && j < M) ? model_mem[i][j] : 32'h0);
      check("idx_err", 32'(idx_err), 32'(model_err));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("no_double_ack", 32'(z_ack), 32'h0);
      end
      @(posedge clk); #1 z_stb = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_done();
      done_in = 1'b1;
      @(posedge clk); #1 done_in = 1'b0;
   endtask

   // drains with either the fixed ready pattern or random ready; abort>0 resets after that many beats
   task automatic do_drain(input bit use_pat, input int abort);
      bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      int base;
      bit done_ok;
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++)
            exp_q.push_back('{i, j, model_mem[i][j], (i == M - 1) && (j == M - 1)});
      base = acc_cnt;
      done_ok = 1'b0;
      for (int c = 0; c < 300 && !done_ok; c++) begin
         @(posedge clk); #1;
         out_ready = (use_pat && c < 5) ? pat[c] : 1'($urandom_range(0, 1));
         start = (c == 1);
         if (abort > 0 && acc_cnt - base >= abort) begin
            #2 rst = 1'b0;
            #1;
            check("rst_out_valid", 32'(out_valid), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_out_data", out_data, 32'h0);
            check("rst_out_last", 32'(out_last), 32'h0);
            exp_q.delete();
            model_clear();
            @(negedge clk) rst = 1'b1;
            done_ok = 1'b1;
         end else if (!busy && c > 1) begin
            done_ok = 1'b1;
         end
      end
      start = 1'b0;
      out_ready = 1'b0;
      check("drain_finished", 32'(done_ok), 32'h1);
      check("drain_q_empty", 32'(exp_q.size()), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_valid", 32'(out_valid), 32'h0);
   endtask

   initial begin
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_ack", 32'(z_ack), 32'h0);
      check("reset_valid", 32'(out_valid), 32'h0);
      check("reset_err", 32'(idx_err), 32'h0);
      check("reset_data", out_data, 32'h0);
      @(negedge clk) rst = 1'b1;

      // directed round: held strobe, overwrite, strobe together with done
      do_start();
      do_write(1, 0, 32'h3F800000, 2, 1'b0);
      do_write(0, 1, 32'h40000000, 0, 1'b0);
      do_write(0, 1, 32'h40400000, 1, 1'b0);
      do_write(1, 1, 32'h41200000, 0, 1'b1);
      do_drain(1'b1, 0);

      // out-of-range index first, then random traffic
      for (int r = 0; r < 4; r++) begin
         int nw;
         do_start();
         if (r == 1) do_write(3, 1, 32'hDEADBEEF, 0, 1'b0);
         nw = $urandom_range(3, 8);
         for (int w = 0; w < nw; w++)
            do_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(0, 2),
                     (r == 2) && (w == nw - 1));
         if (r != 2) do_done();
         do_drain(1'b0, 0);
      end

      // reset in the middle of a drain, then a fresh buffer reads all zero
      do_start();
      for (int w = 0; w < 4; w++)
         do_write($urandom_range(0, 2), $urandom_range(0, 2), $urandom | 32'h1, 0, 1'b0);
      do_done();
      do_drain(1'b0, 2);
      do_start();
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++) begin
            z_i = ML'(i); z_j = ML'(j);
            #1 check("post_rst_zero", current_element, 32'h0);
         end
      do_done();
      do_drain(1'b0, 0);

      // strobe while idle is ignored
      z_i = 2'd0; z_j = 2'd0; z_in = 32'h12345678; z_stb = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_no_ack", 32'(z_ack), 32'h0);
      end
      check("idle_no_write", current_element, model_mem[0][0]);
      z_stb = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
